// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results stay on quotient/remainder/div_by_zero until the next operation completes.
module seq_restoring_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [N:0]     rem_r;
  logic [N-1:0]   dvd_r;
  logic [N-1:0]   dvs_r;
  logic [CW-1:0]  cnt_r;
  logic           busy_r;
  logic           done_r;
  logic [N-1:0]   quotient_r;
  logic [N-1:0]   remainder_r;
  logic           dbz_r;

  logic [N:0]     shifted_s;
  logic [N+1:0]   diff_s;
  logic           borrow_s;
  logic [N:0]     rem_next_s;
  logic [N-1:0]   q_next_s;

  // One restoring iteration: shift, trial subtract, keep or restore.
  always_comb begin
    shifted_s = {rem_r[N-1:0], dvd_r[N-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, dvs_r};
    borrow_s  = diff_s[N+1];
    if (borrow_s) begin
      rem_next_s = shifted_s;
    end else begin
      rem_next_s = diff_s[N:0];
    end
    q_next_s = {dvd_r[N-2:0], ~borrow_s};
  end

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      rem_r       <= {(N+1){1'b0}};
      dvd_r       <= {N{1'b0}};
      dvs_r       <= {N{1'b0}};
      cnt_r       <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {N{1'b0}};
      remainder_r <= {N{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            if (divisor == {N{1'b0}}) begin
              // Divide by zero completes immediately with a saturated quotient.
              quotient_r  <= {N{1'b1}};
              remainder_r <= dividend;
              dbz_r       <= 1'b1;
              done_r      <= 1'b1;
              state_r     <= DONE;
            end else begin
              dvd_r   <= dividend;
              dvs_r   <= divisor;
              rem_r   <= {(N+1){1'b0}};
              cnt_r   <= CW'(N);
              busy_r  <= 1'b1;
              state_r <= CALC;
            end
          end
        end
        CALC: begin
          dvd_r <= q_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            quotient_r  <= q_next_s;
            remainder_r <= rem_next_s[N-1:0];
            dbz_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

  seq_restoring_divider_checker u_checker (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy_r),
    .done       (done_r),
    .state_calc (state_r == CALC),
    .state_done (state_r == DONE),
    .rem_msb    (rem_r[N])
  );

endmodule

// Structural invariants of the divider control path.
module seq_restoring_divider_checker (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done,
  input logic state_calc,
  input logic state_done,
  input logic rem_msb
);

  a_busy_is_calc: assert property (@(posedge clk) disable iff (rst) busy == state_calc);
  a_done_is_done: assert property (@(posedge clk) disable iff (rst) done == state_done);
  a_done_pulse:   assert property (@(posedge clk) disable iff (rst) done |=> !done);
  // The restored partial remainder is always below the divisor, so its top bit stays clear.
  a_rem_msb:      assert property (@(posedge clk) disable iff (rst) !rem_msb);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed checks of seq_restoring_divider at N=8 and N=16 with hand-computed results.
module tb_seq_restoring_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sel;
  logic [15:0] dividend;
  logic [15:0] divisor;

  logic        start8, start16;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;
  logic        busy16, done16, dbz16;
  logic [15:0] q16, r16;

  logic        busy_o, done_o, dbz_o;
  logic [15:0] q_o, r_o;

  int n_tests;
  int n_fail;

  assign start8  = start & ~sel;
  assign start16 = start & sel;
  assign busy_o  = sel ? busy16 : busy8;
  assign done_o  = sel ? done16 : done8;
  assign dbz_o   = sel ? dbz16 : dbz8;
  assign q_o     = sel ? q16 : {8'h00, q8};
  assign r_o     = sel ? r16 : {8'h00, r8};

  seq_restoring_divider #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend[7:0]), .divisor(divisor[7:0]),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  seq_restoring_divider #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(dividend), .divisor(divisor),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_by_zero(dbz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one operation on the selected DUT and check result, latency and handshake.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int exp_q, input int exp_r, input int exp_dbz,
                        input int exp_lat, input int exp_busy);
    int lat, busy_n;
    logic got;
    logic [15:0] q, r;
    logic dbz;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    lat    = 1;
    busy_n = 0;
    got    = 1'b0;
    q = 16'h0; r = 16'h0; dbz = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy_o) busy_n++;
      if (done_o) begin
        got = 1'b1;
        q   = q_o;
        r   = r_o;
        dbz = dbz_o;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_q"}, 32'(q), 32'(exp_q));
    check({tag, "_r"}, 32'(r), 32'(exp_r));
    check({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
    @(posedge clk); #1;
    check({tag, "_done_single"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    int done_n;
    logic [15:0] a, b, cap_q, cap_r;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    dividend = 16'h0;
    divisor  = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_q8", 32'(q8), 32'd0);
    check("rst_r8", 32'(r8), 32'd0);
    check("rst_dbz8", 32'(dbz8), 32'd0);
    check("rst_q16", 32'(q16), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("d200_7", 16'd200, 16'd7, 28, 4, 0, 9, 8);
    run_op("b2b_255_1", 16'd255, 16'd1, 255, 0, 0, 9, 8);
    run_op("b2b_5_9", 16'd5, 16'd9, 0, 5, 0, 9, 8);
    run_op("b2b_255_128", 16'd255, 16'd128, 1, 127, 0, 9, 8);
    run_op("dz_100_0", 16'd100, 16'd0, 255, 100, 1, 1, 0);
    run_op("after_dz_9_3", 16'd9, 16'd3, 3, 0, 0, 9, 8);

    // A start pulse during CALC must be ignored and operand changes must not matter.
    dividend = 16'd200;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_q_in_calc", 32'(q_o), 32'd3);
    check("busy_in_calc", 32'(busy_o), 32'd1);
    dividend = 16'd10;
    divisor  = 16'd2;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 16'd99;
    divisor  = 16'd5;
    done_n = 0;
    cap_q  = 16'h0;
    cap_r  = 16'h0;
    for (int i = 0; i < 14; i++) begin
      if (done_o) begin
        done_n++;
        cap_q = q_o;
        cap_r = r_o;
      end
      @(posedge clk); #1;
    end
    check("ign_done_count", 32'(done_n), 32'd1);
    check("ign_q", 32'(cap_q), 32'd28);
    check("ign_r", 32'(cap_r), 32'd4);

    // Asynchronous reset between edges in the middle of CALC.
    dividend = 16'd200;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_done", 32'(done_o), 32'd0);
    check("arst_q", 32'(q_o), 32'd0);
    check("arst_r", 32'(r_o), 32'd0);
    check("arst_dbz", 32'(dbz_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 14; i++) begin
      if (done_o) done_n++;
      @(posedge clk); #1;
    end
    check("arst_no_done", 32'(done_n), 32'd0);
    check("arst_q_after", 32'(q_o), 32'd0);
    run_op("post_rst_50_6", 16'd50, 16'd6, 8, 2, 0, 9, 8);

    sel = 1'b1;
    run_op("w_0_1", 16'd0, 16'd1, 0, 0, 0, 17, 16);
    run_op("w_1_1", 16'd1, 16'd1, 1, 0, 0, 17, 16);
    run_op("w_ffff_1", 16'hFFFF, 16'd1, 65535, 0, 0, 17, 16);
    run_op("w_ffff_ffff", 16'hFFFF, 16'hFFFF, 1, 0, 0, 17, 16);
    run_op("w_5_ffff", 16'd5, 16'hFFFF, 0, 5, 0, 17, 16);
    run_op("w_ffff_8000", 16'hFFFF, 16'h8000, 1, 32767, 0, 17, 16);
    run_op("w_1000_37", 16'd1000, 16'd37, 27, 1, 0, 17, 16);
    run_op("w_ffff_ff", 16'hFFFF, 16'd255, 257, 0, 0, 17, 16);
    run_op("w_40000_7", 16'd40000, 16'd7, 5714, 2, 0, 17, 16);
    run_op("w_dz_1234", 16'h1234, 16'd0, 65535, 4660, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = (i < 4) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
      run_op("w_rand", a, b, int'(a / b), int'(a % b), 0, 17, 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
